// File: rtl/dac_pkg.sv
// dac_pkg: shared types and helpers for the MCP49x2 SPI DAC driver.
// Holds the FSM state enum, command-bit positions and the word builder.
package dac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_LDAC
    } dac_state_t;

    localparam int CMD_CHAN = 15;
    localparam int CMD_BUF  = 14;
    localparam int CMD_GA   = 13;
    localparam int CMD_SHDN = 12;

    // Signed sample -> offset binary -> top `bits` bits, left-justified
    // into the 12-bit code field, then the four command bits on top.
    function automatic logic [15:0] dac_cmd(
        input logic [15:0] sample,
        input logic        chan,
        input int          bits     = 12,
        input logic        buffered = 1'b0,
        input logic        gain_1x  = 1'b1
    );
        logic [11:0] mask;
        logic [15:0] w;
        mask = 12'hFFF << (12 - bits);
        w = ((sample ^ 16'h8000) & {mask, 4'h0}) >> 4;
        w[CMD_CHAN] = chan;
        w[CMD_BUF]  = buffered;
        w[CMD_GA]   = gain_1x;
        w[CMD_SHDN] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/dac_clk_div.sv
// dac_clk_div: emits a one-cycle tick every SCLK_DIV clocks (one SCLK
// half-period). Ports: audio_clock, reset, hold (clears count), tick.
module dac_clk_div #(
    parameter int SCLK_DIV = 2
) (
    input  logic audio_clock,
    input  logic reset,
    input  logic hold,
    output logic tick
);

    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (hold || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Held at zero while idle so every frame starts on a fresh half-period.
    assign tick = !hold && (count == LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: serialises one frame of signed samples to an MCP49x2 DAC
// (SPI mode 0), then pulses LDAC so all channels update together.
// Ports: audio_clock, reset; data_ready/mosi_in frame input with ready_out
// (buffer empty); sclk_out, sdi_out, cs_n_out, ldac_n_out DAC pins;
// active_out (FSM busy); overrun_count_out (dropped frames, saturating).
module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int clock_max = 25_000_000,
    parameter int SCLK_DIV  = 2,
    parameter int CHANNELS  = 2,
    parameter int DAC_BITS  = 12,
    parameter bit BUFFERED  = 1'b0,
    parameter bit GAIN_1X   = 1'b1
) (
    input  logic                   audio_clock,
    input  logic                   reset,
    input  logic                   data_ready,
    input  logic [CHANNELS*16-1:0] mosi_in,
    output logic                   ready_out,
    output logic                   sclk_out,
    output logic                   sdi_out,
    output logic                   cs_n_out,
    output logic                   ldac_n_out,
    output logic                   active_out,
    output logic [7:0]             overrun_count_out
);

    if (clock_max <= 0 || SCLK_DIV < 1 ||
        (CHANNELS != 1 && CHANNELS != 2) ||
        (DAC_BITS != 8 && DAC_BITS != 10 && DAC_BITS != 12)) begin : g_bad_params
        $error("dac_spi_driver: unsupported parameter set");
    end

    localparam logic LAST_CHAN = (CHANNELS == 2);

    dac_state_t state, state_d;
    logic [4:0] half, half_d;
    logic chan, chan_d;
    logic [CHANNELS*16-1:0] frame_buf, work, work_d;
    logic start, tick, sdi_d;
    logic [15:0] sample, word;

    dac_clk_div #(
        .SCLK_DIV(SCLK_DIV)
    ) u_div (
        .audio_clock(audio_clock),
        .reset(reset),
        .hold(state == S_IDLE),
        .tick(tick)
    );

    always_comb begin
        state_d = state;
        half_d  = half;
        chan_d  = chan;
        work_d  = work;
        start   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!ready_out) begin
                    start   = 1'b1;
                    work_d  = frame_buf;
                    chan_d  = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    half_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (half == 5'd31) state_d = S_HOLD;
                    else half_d = half + 5'd1;
                end
            end
            S_HOLD: begin
                if (tick) state_d = S_GAP;
            end
            S_GAP: begin
                if (tick) begin
                    if (chan == LAST_CHAN) begin
                        state_d = S_LDAC;
                    end else begin
                        chan_d  = chan + 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_LDAC: begin
                if (tick) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    if (CHANNELS == 2) begin : g_two
        assign sample = chan_d ? work_d[31:16] : work_d[15:0];
    end else begin : g_one
        assign sample = work_d[15:0];
    end

    assign word = dac_cmd(sample, chan_d, DAC_BITS, BUFFERED, GAIN_1X);

    // Within SHIFT each bit spans two halves (low, high), so the bit index
    // only moves on the low half and SDI is stable across the rising edge.
    always_comb begin
        sdi_d = 1'b0;
        unique case (state_d)
            S_SETUP: sdi_d = word[15];
            S_SHIFT: sdi_d = word[~half_d[4:1]];
            S_HOLD:  sdi_d = word[0];
            default: sdi_d = 1'b0;
        endcase
    end

    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            half  <= '0;
            chan  <= 1'b0;
            work  <= '0;
        end else begin
            state <= state_d;
            half  <= half_d;
            chan  <= chan_d;
            work  <= work_d;
        end
    end

    // Outputs are registered from the next state so the pins change on
    // the same edge as the FSM.
    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            sclk_out   <= 1'b0;
            sdi_out    <= 1'b0;
            cs_n_out   <= 1'b1;
            ldac_n_out <= 1'b1;
            active_out <= 1'b0;
        end else begin
            sclk_out   <= (state_d == S_SHIFT) && half_d[0];
            sdi_out    <= sdi_d;
            cs_n_out   <= !(state_d inside {S_SETUP, S_SHIFT, S_HOLD});
            ldac_n_out <= (state_d != S_LDAC);
            active_out <= (state_d != S_IDLE);
        end
    end

    // ready_out doubles as the buffer-empty flag; acceptance and overrun
    // are judged against its registered value.
    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            ready_out         <= 1'b1;
            frame_buf         <= '0;
            overrun_count_out <= '0;
        end else begin
            if (data_ready && ready_out) begin
                frame_buf <= mosi_in;
                ready_out <= 1'b0;
            end else if (start) begin
                ready_out <= 1'b1;
            end
            if (data_ready && !ready_out && overrun_count_out != 8'hFF) begin
                overrun_count_out <= overrun_count_out + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: random and directed frames into two driver variants,
// checked against a frame-level timing and word model.
`timescale 1ns/1ps
module tb_dac_spi_driver;

    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dr = 1'b0;
    logic [31:0] mosi = '0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Command word from the datasheet rules using plain arithmetic.
    function automatic logic [15:0] ref_word(input logic [15:0] s, input int k,
                                             input int bits, input int bufv,
                                             input int ga);
        int ob, code;
        ob = int'(signed'(s)) + 32768;
        code = (ob >> (16 - bits)) << (12 - bits);
        return 16'(k * 32768 + bufv * 16384 + ga * 8192 + 4096 + code);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int CH   = (g == 0) ? 2 : 1;
        localparam int BITS = (g == 0) ? 12 : 8;
        localparam bit BV   = (g != 0);
        localparam bit GA   = (g == 0);
        localparam int L    = (35 * CH + 1) * DIV;

        logic ready, sclk, sdi, cs_n, ldac_n, active;
        logic [7:0] ovr;

        dac_spi_driver #(
            .clock_max(25_000_000),
            .SCLK_DIV(DIV),
            .CHANNELS(CH),
            .DAC_BITS(BITS),
            .BUFFERED(BV),
            .GAIN_1X(GA)
        ) dut (
            .audio_clock(clk),
            .reset(rst),
            .data_ready(dr),
            .mosi_in(mosi[CH*16-1:0]),
            .ready_out(ready),
            .sclk_out(sclk),
            .sdi_out(sdi),
            .cs_n_out(cs_n),
            .ldac_n_out(ldac_n),
            .active_out(active),
            .overrun_count_out(ovr)
        );

        // Model: edge count e, frame end edge m_end, buffer occupancy.
        logic [CH*16-1:0] m_buf;
        logic m_full, b2b;
        int e, m_end, m_ovr;
        logic [15:0] expq[$];

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_full = 1'b0;
                b2b = 1'b0;
                e = 0;
                m_end = -1;
                m_ovr = 0;
                expq.delete();
            end else begin
                logic was_ready;
                e = e + 1;
                was_ready = !m_full;
                if (e > m_end && m_full) begin
                    for (int k = 0; k < CH; k++)
                        expq.push_back(ref_word(m_buf[k*16 +: 16], k, BITS,
                                                int'(BV), int'(GA)));
                    b2b = (m_end == e - 1);
                    m_end = e + L;
                    m_full = 1'b0;
                end
                if (dr) begin
                    if (was_ready) begin
                        m_full = 1'b1;
                        m_buf = mosi[CH*16-1:0];
                    end else if (m_ovr < 255) begin
                        m_ovr++;
                    end
                end
            end
        end

        int cyc, act_rise, ldac_lo, last_ldac, nb;
        logic [15:0] sh;
        logic p_sclk, p_sdi, p_cs, p_ldac, p_act;

        always @(negedge clk) begin
            if (rst) begin
                cyc = 0; nb = 0; ldac_lo = 0; last_ldac = -100; act_rise = 0;
                sh = '0;
                p_sclk = 1'b0; p_sdi = 1'b0; p_cs = 1'b1;
                p_ldac = 1'b1; p_act = 1'b0;
            end else begin
                cyc++;
                check($sformatf("u%0d_ready", g), ready, !m_full);
                check($sformatf("u%0d_active", g), active, e < m_end);
                check($sformatf("u%0d_overrun", g), ovr, m_ovr);
                if (p_cs && !cs_n) begin
                    nb = 0;
                    sh = '0;
                    if (!p_act) begin
                        check($sformatf("u%0d_cs_with_active", g), active, 1);
                        if (b2b)
                            check($sformatf("u%0d_b2b_gap", g),
                                  cyc - last_ldac, 2);
                    end
                end
                if (!cs_n && sclk && !p_sclk) begin
                    check($sformatf("u%0d_sdi_stable", g), sdi, p_sdi);
                    sh = {sh[14:0], sdi};
                    nb++;
                end
                if (!p_cs && cs_n) begin
                    check($sformatf("u%0d_bits", g), nb, 16);
                    check($sformatf("u%0d_expq", g), expq.size() > 0, 1);
                    if (expq.size() > 0)
                        check($sformatf("u%0d_word", g), sh, expq.pop_front());
                end
                if (!ldac_n) ldac_lo++;
                if (!p_ldac && ldac_n) begin
                    check($sformatf("u%0d_ldac_len", g), ldac_lo, DIV);
                    check($sformatf("u%0d_ldac_last", g), active, 0);
                    check($sformatf("u%0d_ldac_cs", g), cs_n, 1);
                    ldac_lo = 0;
                    last_ldac = cyc - 1;
                end
                if (active && !p_act) act_rise = cyc;
                if (!active && p_act) begin
                    check($sformatf("u%0d_frame_len", g), cyc - act_rise, L);
                    check($sformatf("u%0d_words_done", g), expq.size(), 0);
                end
                p_sclk = sclk; p_sdi = sdi; p_cs = cs_n;
                p_ldac = ldac_n; p_act = active;
            end
        end
    end

    task automatic chk_reset(input string tag);
        check({tag, "_sclk"},   {u[0].sclk, u[1].sclk}, 2'b00);
        check({tag, "_sdi"},    {u[0].sdi, u[1].sdi}, 2'b00);
        check({tag, "_cs_n"},   {u[0].cs_n, u[1].cs_n}, 2'b11);
        check({tag, "_ldac_n"}, {u[0].ldac_n, u[1].ldac_n}, 2'b11);
        check({tag, "_active"}, {u[0].active, u[1].active}, 2'b00);
        check({tag, "_ready"},  {u[0].ready, u[1].ready}, 2'b11);
        check({tag, "_ovr"},    {u[0].ovr, u[1].ovr}, 16'h0000);
    endtask

    task automatic send(input logic [31:0] d);
        dr = 1'b1;
        mosi = d;
        @(negedge clk);
        dr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((u[0].active || !u[0].ready || u[1].active || !u[1].ready)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < budget, 1);
    endtask

    logic [31:0] pats[6];

    initial begin
        pats[0] = {16'h8000, 16'h0000};
        pats[1] = {16'h7FFF, 16'h7FFF};
        pats[2] = {16'hFFFF, 16'h8000};
        pats[3] = {16'h0001, 16'hFFFF};
        pats[4] = {16'h1234, 16'h0000};
        pats[5] = {16'h0000, 16'h8001};
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        @(negedge clk);

        foreach (pats[i]) begin
            send(pats[i]);
            wait_idle(400);
        end
        repeat (6) begin
            send($urandom);
            wait_idle(400);
        end

        // Accept, drop in the freeing cycle, accept, then drop while full.
        dr = 1'b1;
        mosi = $urandom;
        @(negedge clk);
        mosi = $urandom;
        @(negedge clk);
        mosi = $urandom;
        @(negedge clk);
        dr = 1'b0;
        repeat (3) @(negedge clk);
        send($urandom);
        wait_idle(1000);
        check("ovr_after_b2b", u[0].ovr, 8'd2);

        // Saturate the overrun counter, then random strobes.
        dr = 1'b1;
        repeat (400) begin
            mosi = $urandom;
            @(negedge clk);
        end
        check("ovr_saturated", u[0].ovr, 8'd255);
        repeat (600) begin
            dr = 1'($urandom_range(0, 1));
            mosi = $urandom;
            @(negedge clk);
        end
        dr = 1'b0;
        wait_idle(1000);

        // Asynchronous reset in the middle of SHIFT.
        send($urandom);
        repeat (12) @(negedge clk);
        check("pre_reset_busy", u[0].active, 1);
        #2 rst = 1'b1;
        #1 chk_reset("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("no_resume_cs", {u[0].cs_n, u[1].cs_n}, 2'b11);

        send({16'hC000, 16'h4000});
        wait_idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
